adxl345_spi_responder: RTL and testbench

SPI slave that answers the accelerometer controller's register protocol (ADXL345 subset, SPI mode 3), so the signal path can run against synthetic or replayed samples without the physical sensor. It sits in the bench and hardware-in-the-loop build in place of the ADXL345 pins. It oversamples SCLK, CS and MOSI on `sys_clk`, decodes command bytes and serves a small register file. Axis samples are snapshotted at the start of each transaction so that every burst read is coherent.

---
 rtl/adxl345_spi_responder_if.sv | 31 +++
 rtl/adxl345_spi_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_adxl345_spi_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/adxl345_spi_responder_if.sv
// ---------------------------------------------------------------------------
// adxl345_spi_responder_if
//
// Four-wire SPI bus between an accelerometer controller (master) and the
// ADXL345 stand-in responder (slave).
//
//   spi_sclk  master -> slave  SPI clock, idles high (mode 3)
//   spi_cs    master -> slave  chip select, active low
//   spi_mosi  master -> slave  master-out data
//   spi_miso  slave -> master  slave-out data
// ---------------------------------------------------------------------------
interface adxl345_spi_responder_if;
    logic spi_sclk;
    logic spi_cs;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_cs,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/adxl345_spi_responder.sv
// ---------------------------------------------------------------------------
// adxl345_spi_responder
//
// SPI mode-3 slave that mimics the register protocol of an ADXL345 so the
// accelerometer signal path can run on synthetic or replayed samples. The
// SPI pins are oversampled on sys_clk; axis samples are snapshotted when CS
// falls so that a multi-byte burst read always returns one coherent sample.
//
// Ports
//   sys_clk       system clock, rising edge
//   rst_n         asynchronous active-low reset
//   spi           SPI bus (slave modport): sclk, cs, mosi in; miso out
//   x/y/z_sample  signed 16-bit axis values
//   sample_valid  one-cycle strobe loading x/y/z into the live registers
//   bw_rate       register 0x2C
//   power_ctl     register 0x2D
//   data_format   register 0x31
//   txn_done      one-cycle pulse after CS rises at the end of a transaction
// ---------------------------------------------------------------------------
module adxl345_spi_responder #(
    parameter int unsigned CLK_RATIO_MIN = 8,
    parameter logic [7:0]  DEVID         = 8'hE5
) (
    input  logic                      sys_clk,
    input  logic                      rst_n,
    adxl345_spi_responder_if.slave    spi,
    input  logic signed [15:0]        x_sample,
    input  logic signed [15:0]        y_sample,
    input  logic signed [15:0]        z_sample,
    input  logic                      sample_valid,
    output logic [7:0]                bw_rate,
    output logic [7:0]                power_ctl,
    output logic [7:0]                data_format,
    output logic                      txn_done
);

    // The edge-detect and MISO latency only fit inside half an SCLK period
    // when sys_clk runs at least 8x faster than SCLK.
    if (CLK_RATIO_MIN < 8) begin : g_ratio_check
        $error("adxl345_spi_responder: CLK_RATIO_MIN must be at least 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RDATA = 2'd2,
        ST_WDATA = 2'd3
    } state_t;

    localparam logic [5:0] ADDR_DEVID   = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE = 6'h2C;
    localparam logic [5:0] ADDR_PWR_CTL = 6'h2D;
    localparam logic [5:0] ADDR_DFORMAT = 6'h31;
    localparam logic [5:0] ADDR_X0      = 6'h32;
    localparam logic [5:0] ADDR_X1      = 6'h33;
    localparam logic [5:0] ADDR_Y0      = 6'h34;
    localparam logic [5:0] ADDR_Y1      = 6'h35;
    localparam logic [5:0] ADDR_Z0      = 6'h36;
    localparam logic [5:0] ADDR_Z1      = 6'h37;

    // Synchroniser stages: _p0/_p1 resolve metastability, _p2 is the
    // previous synchronised value used for edge detection.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;

    logic rise, fall, cs_fall, cs_rise;

    state_t state_q, state_d;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] rx_next;
    logic [7:0] tx_shift;
    logic [5:0] addr;
    logic [5:0] addr_nxt;
    logic       mb;
    logic       miso_q;

    logic signed [15:0] live_x, live_y, live_z;
    logic signed [15:0] snap_x, snap_y, snap_z;

    // ---- stage p0..p2: pin synchronisation and edge history ----
    // CS history resets low so that a CS already held low when reset is
    // released produces no cs_fall; the transaction has to start afresh.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p0 <= 1'b1;
            sclk_p1 <= 1'b1;
            sclk_p2 <= 1'b1;
            cs_p0   <= 1'b0;
            cs_p1   <= 1'b0;
            cs_p2   <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= spi.spi_sclk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= spi.spi_cs;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= spi.spi_mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    // SCLK edges only count while the synchronised CS is low.
    assign rise    =  sclk_p1 & ~sclk_p2 & ~cs_p1;
    assign fall    = ~sclk_p1 &  sclk_p2 & ~cs_p1;
    assign cs_fall = ~cs_p1 &  cs_p2;
    assign cs_rise =  cs_p1 & ~cs_p2;

    assign rx_next  = {rx_shift[6:0], mosi_p1};
    assign addr_nxt = mb ? addr + 6'd1 : addr;

    // Register file read mux; unmapped addresses read zero.
    function automatic logic [7:0] reg_rd(input logic [5:0] a);
        logic [7:0] d;
        d = 8'h00;
        case (a)
            ADDR_DEVID:   d = DEVID;
            ADDR_BW_RATE: d = bw_rate;
            ADDR_PWR_CTL: d = power_ctl;
            ADDR_DFORMAT: d = data_format;
            ADDR_X0:      d = snap_x[7:0];
            ADDR_X1:      d = snap_x[15:8];
            ADDR_Y0:      d = snap_y[7:0];
            ADDR_Y1:      d = snap_y[15:8];
            ADDR_Z0:      d = snap_z[7:0];
            ADDR_Z1:      d = snap_z[15:8];
            default:      d = 8'h00;
        endcase
        return d;
    endfunction

    // ---- FSM state register ----
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rise && bit_cnt == 3'd7) begin
                    state_d = rx_next[7] ? ST_RDATA : ST_WDATA;
                end
            end
            default: state_d = state_q;
        endcase
        if (cs_rise) begin
            state_d = ST_IDLE;
        end
    end

    // ---- live sample registers ----
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            live_x <= '0;
            live_y <= '0;
            live_z <= '0;
        end else if (sample_valid) begin
            live_x <= x_sample;
            live_y <= y_sample;
            live_z <= z_sample;
        end
    end

    // ---- shift datapath, snapshot and register file ----
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            addr        <= 6'h00;
            mb          <= 1'b0;
            miso_q      <= 1'b0;
            txn_done    <= 1'b0;
            snap_x      <= '0;
            snap_y      <= '0;
            snap_z      <= '0;
            bw_rate     <= 8'h0A;
            power_ctl   <= 8'h00;
            data_format <= 8'h00;
        end else if (cs_rise) begin
            // End of transaction: any partially shifted byte is dropped.
            txn_done <= (state_q != ST_IDLE);
            miso_q   <= 1'b0;
            bit_cnt  <= 3'd0;
        end else begin
            txn_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= 3'd0;
                        // A strobe coinciding with CS falling wins, so the
                        // snapshot never lags the newest sample.
                        snap_x  <= sample_valid ? x_sample : live_x;
                        snap_y  <= sample_valid ? y_sample : live_y;
                        snap_z  <= sample_valid ? z_sample : live_z;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr <= rx_next[5:0];
                            mb   <= rx_next[6];
                            if (rx_next[7]) begin
                                tx_shift <= reg_rd(rx_next[5:0]);
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (fall) begin
                        miso_q   <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    if (rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            addr     <= addr_nxt;
                            tx_shift <= reg_rd(addr_nxt);
                        end
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (addr)
                                ADDR_BW_RATE: bw_rate     <= rx_next;
                                ADDR_PWR_CTL: power_ctl   <= rx_next;
                                ADDR_DFORMAT: data_format <= rx_next;
                                default:      ;
                            endcase
                            addr <= addr_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi.spi_miso = miso_q;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_adxl345_spi_responder
//
// Directed bench for the ADXL345 SPI responder. Drives an SPI mode-3 master
// at a sys_clk/SCLK ratio of 10 and checks read data, register writes,
// snapshot coherence, address wrap, aborted writes and reset behaviour.
// ---------------------------------------------------------------------------
module tb_adxl345_spi_responder;

    logic               sys_clk;
    logic               rst_n;
    logic signed [15:0] x_sample, y_sample, z_sample;
    logic               sample_valid;
    logic [7:0]         bw_rate, power_ctl, data_format;
    logic               txn_done;

    int vectors     = 0;
    int miscompares = 0;

    adxl345_spi_responder_if spi_if ();

    adxl345_spi_responder #(
        .CLK_RATIO_MIN (8),
        .DEVID         (8'hE5)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .spi          (spi_if.slave),
        .x_sample     (x_sample),
        .y_sample     (y_sample),
        .z_sample     (z_sample),
        .sample_valid (sample_valid),
        .bw_rate      (bw_rate),
        .power_ctl    (power_ctl),
        .data_format  (data_format),
        .txn_done     (txn_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cs_start();
        @(negedge sys_clk);
        spi_if.spi_cs = 1'b0;
        repeat (6) @(negedge sys_clk);
    endtask

    // Raise CS and count txn_done pulses over a bounded window.
    task automatic cs_end(input string tag, input int exp_pulses);
        int pulses;
        repeat (2) @(negedge sys_clk);
        spi_if.spi_cs = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (txn_done === 1'b1) pulses++;
        end
        if (exp_pulses >= 0) begin
            chk({tag, "_txn_done"}, 16'(pulses), 16'(exp_pulses));
            chk({tag, "_miso_idle"}, {15'd0, spi_if.spi_miso}, 16'd0);
        end
    endtask

    // Shift nbits of tx MSB first; MISO is sampled just before each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge sys_clk);
            spi_if.spi_sclk = 1'b0;
            spi_if.spi_mosi = tx[7-i];
            repeat (5) @(negedge sys_clk);
            rx[7-i] = spi_if.spi_miso;
            spi_if.spi_sclk = 1'b1;
            repeat (4) @(negedge sys_clk);
        end
    endtask

    task automatic load_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge sys_clk);
        x_sample     = x;
        y_sample     = y;
        z_sample     = z;
        sample_valid = 1'b1;
        @(negedge sys_clk);
        sample_valid = 1'b0;
    endtask

    logic [7:0] rd;

    initial begin
        rst_n           = 1'b0;
        spi_if.spi_sclk = 1'b1;
        spi_if.spi_cs   = 1'b1;
        spi_if.spi_mosi = 1'b0;
        x_sample        = '0;
        y_sample        = '0;
        z_sample        = '0;
        sample_valid    = 1'b0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_miso",        {15'd0, spi_if.spi_miso}, 16'd0);
        chk("rst_txn_done",    {15'd0, txn_done}, 16'd0);
        chk("rst_bw_rate",     {8'd0, bw_rate}, 16'h000A);
        chk("rst_power_ctl",   {8'd0, power_ctl}, 16'h0000);
        chk("rst_data_format", {8'd0, data_format}, 16'h0000);
        rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("post_rst_txn_done", {15'd0, txn_done}, 16'd0);

        // DEVID read
        cs_start();
        xfer(8'h80, 8, rd);
        xfer(8'h00, 8, rd);
        chk("devid", {8'd0, rd}, 16'h00E5);
        cs_end("devid", 1);

        // Burst read of all six axis bytes
        load_sample(16'h1234, 16'hFF80, 16'h0100);
        cs_start();
        xfer(8'hF2, 8, rd);
        xfer(8'h00, 8, rd); chk("burst_x0", {8'd0, rd}, 16'h0034);
        xfer(8'h00, 8, rd); chk("burst_x1", {8'd0, rd}, 16'h0012);
        xfer(8'h00, 8, rd); chk("burst_y0", {8'd0, rd}, 16'h0080);
        xfer(8'h00, 8, rd); chk("burst_y1", {8'd0, rd}, 16'h00FF);
        xfer(8'h00, 8, rd); chk("burst_z0", {8'd0, rd}, 16'h0000);
        xfer(8'h00, 8, rd); chk("burst_z1", {8'd0, rd}, 16'h0001);
        cs_end("burst", 1);

        // Snapshot coherence: new sample mid-burst must not leak in
        load_sample(16'h1111, 16'h0000, 16'h0000);
        cs_start();
        xfer(8'hF2, 8, rd);
        xfer(8'h00, 8, rd); chk("coh_x0", {8'd0, rd}, 16'h0011);
        load_sample(16'hAAAA, 16'h0000, 16'h0000);
        xfer(8'h00, 8, rd); chk("coh_x1", {8'd0, rd}, 16'h0011);
        cs_end("coh", 1);
        cs_start();
        xfer(8'hF2, 8, rd);
        xfer(8'h00, 8, rd); chk("coh_next_x0", {8'd0, rd}, 16'h00AA);
        xfer(8'h00, 8, rd); chk("coh_next_x1", {8'd0, rd}, 16'h00AA);
        cs_end("coh_next", 1);

        // Write POWER_CTL
        cs_start();
        xfer(8'h2D, 8, rd);
        xfer(8'h08, 8, rd);
        cs_end("wr_pwr", 1);
        chk("power_ctl", {8'd0, power_ctl}, 16'h0008);

        // Write BW_RATE and read it back
        cs_start();
        xfer(8'h2C, 8, rd);
        xfer(8'h0F, 8, rd);
        cs_end("wr_bw", 1);
        chk("bw_rate", {8'd0, bw_rate}, 16'h000F);
        cs_start();
        xfer(8'hAC, 8, rd);
        xfer(8'h00, 8, rd);
        chk("bw_rate_rd", {8'd0, rd}, 16'h000F);
        cs_end("rd_bw", 1);

        // Write to read-only DEVID is ignored
        cs_start();
        xfer(8'h00, 8, rd);
        xfer(8'h55, 8, rd);
        cs_end("wr_devid", 1);
        cs_start();
        xfer(8'h80, 8, rd);
        xfer(8'h00, 8, rd);
        chk("devid_after_wr", {8'd0, rd}, 16'h00E5);
        cs_end("devid2", 1);

        // Address wrap 0x3F -> 0x00
        cs_start();
        xfer(8'hFF, 8, rd);
        xfer(8'h00, 8, rd); chk("wrap_3f", {8'd0, rd}, 16'h0000);
        xfer(8'h00, 8, rd); chk("wrap_00", {8'd0, rd}, 16'h00E5);
        cs_end("wrap", 1);

        // Aborted write of 0xFF to DATA_FORMAT after 4 data bits
        cs_start();
        xfer(8'h31, 8, rd);
        xfer(8'hFF, 4, rd);
        cs_end("abort", 1);
        chk("abort_data_format", {8'd0, data_format}, 16'h0000);
        cs_start();
        xfer(8'hB1, 8, rd);
        xfer(8'h00, 8, rd);
        chk("abort_rd", {8'd0, rd}, 16'h0000);
        cs_end("abort_rd", 1);

        // Reset mid-transaction with CS held low: not a new start
        cs_start();
        xfer(8'h2C, 4, rd);
        @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst_miso", {15'd0, spi_if.spi_miso}, 16'd0);
        chk("midrst_bw_rate", {8'd0, bw_rate}, 16'h000A);
        rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        xfer(8'h2C, 8, rd);
        xfer(8'h33, 8, rd);
        cs_end("midrst", -1);
        chk("midrst_no_write", {8'd0, bw_rate}, 16'h000A);

        // Fresh transaction after the aborted one works normally
        cs_start();
        xfer(8'h80, 8, rd);
        xfer(8'h00, 8, rd);
        chk("devid_after_rst", {8'd0, rd}, 16'h00E5);
        cs_end("devid3", 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
